// File: rtl/rv32_fetch.sv
// rv32_fetch: RV32 instruction fetch stage.
// Owns the PC, issues word reads to instruction memory and fills the IF/ID
// pipeline register (pc_out/instr_out). Honours hazard stall/flush and
// redirects on taken branches. A NOP (addi x0,x0,0) is inserted whenever no
// instruction is delivered.
// Optional feature: define RV32_FETCH_BUFFER_EN to add a one-entry buffer that
// captures a response arriving during a stall, so memory is not re-read.
module rv32_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_pc_in,
    output logic        instr_read_out,
    output logic [31:0] instr_address_out,
    input  logic        instr_ready_in,
    input  logic [31:0] instr_read_value_in,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
`ifdef RV32_FETCH_BUFFER_EN
        ,
        BUFFERED = 2'd3
`endif
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] redirect_pc_reg, redirect_pc_next;
    logic [31:0] ifid_pc_reg, ifid_pc_next;
    logic [31:0] ifid_instr_reg, ifid_instr_next;
    logic        ifid_load;
    logic [31:0] branch_target;
    logic [31:0] pc_plus4;

`ifdef RV32_FETCH_BUFFER_EN
    logic [31:0] buffer_reg, buffer_next;
`endif

    // Branch targets are forced to a word boundary; the increment wraps mod 2^32.
    assign branch_target = branch_pc_in & 32'hFFFF_FFFC;
    assign pc_plus4      = pc_reg + 32'd4;

    // The request address is always the current PC; in DISCARD that is the
    // stale address still owed a response.
    assign instr_address_out = pc_reg;
    assign instr_read_out    = (state_reg == FETCH) || (state_reg == DISCARD);

    assign pc_out    = ifid_pc_reg;
    assign instr_out = ifid_instr_reg;

    // Next-state, PC and IF/ID selection.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        redirect_pc_next = redirect_pc_reg;
        ifid_load        = !stall_in;
        ifid_pc_next     = pc_reg;
        ifid_instr_next  = NOP;
`ifdef RV32_FETCH_BUFFER_EN
        buffer_next      = buffer_reg;
`endif
        case (state_reg)
            IDLE: begin
                state_next = FETCH;
                if (branch_taken_in) begin
                    pc_next = branch_target;
                end
            end
            FETCH: begin
                if (branch_taken_in) begin
                    if (instr_ready_in) begin
                        // Response is in hand, so the redirect can happen now.
                        pc_next = branch_target;
                    end else begin
                        // Read still outstanding: keep the address stable and
                        // throw its eventual response away.
                        redirect_pc_next = branch_target;
                        state_next       = DISCARD;
                    end
                end else if (instr_ready_in && !stall_in) begin
                    pc_next = pc_plus4;
                    if (!flush_in) begin
                        ifid_instr_next = instr_read_value_in;
                    end
                end else if (instr_ready_in && stall_in) begin
`ifdef RV32_FETCH_BUFFER_EN
                    buffer_next = instr_read_value_in;
                    state_next  = BUFFERED;
`endif
                end
            end
            DISCARD: begin
                if (instr_ready_in) begin
                    pc_next    = branch_taken_in ? branch_target : redirect_pc_reg;
                    state_next = FETCH;
                end else if (branch_taken_in) begin
                    redirect_pc_next = branch_target;
                end
            end
`ifdef RV32_FETCH_BUFFER_EN
            BUFFERED: begin
                if (branch_taken_in) begin
                    pc_next    = branch_target;
                    state_next = FETCH;
                end else if (!stall_in) begin
                    pc_next    = pc_plus4;
                    state_next = FETCH;
                    if (!flush_in) begin
                        ifid_instr_next = buffer_reg;
                    end
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Fetch control state: FSM, PC and pending redirect target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_VECTOR;
            redirect_pc_reg <= RESET_VECTOR;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            redirect_pc_reg <= redirect_pc_next;
        end
    end

    // IF/ID pipeline register; frozen while the hazard unit stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_pc_reg    <= RESET_VECTOR;
            ifid_instr_reg <= NOP;
        end else if (ifid_load) begin
            ifid_pc_reg    <= ifid_pc_next;
            ifid_instr_reg <= ifid_instr_next;
        end
    end

`ifdef RV32_FETCH_BUFFER_EN
    // Holds a response that arrived while decode was stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer_reg <= NOP;
        end else begin
            buffer_reg <= buffer_next;
        end
    end
`endif

endmodule

// File: tb/tb_rv32_fetch.sv
// Directed testbench for rv32_fetch (RESET_VECTOR = 0x100).
// Memory model returns {16'hC0DE, address[15:0]} for every address, so the
// expected instruction for any fetch is a hand-written constant.
module tb_rv32_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        flush_in;
    logic        branch_taken_in;
    logic [31:0] branch_pc_in;
    logic        instr_read_out;
    logic [31:0] instr_address_out;
    logic        instr_ready_in;
    logic [31:0] instr_read_value_in;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    int tests_run;
    int tests_failed;

    rv32_fetch #(.RESET_VECTOR(32'h0000_0100)) dut (
        .clk                 (clk),
        .reset               (reset),
        .stall_in            (stall_in),
        .flush_in            (flush_in),
        .branch_taken_in     (branch_taken_in),
        .branch_pc_in        (branch_pc_in),
        .instr_read_out      (instr_read_out),
        .instr_address_out   (instr_address_out),
        .instr_ready_in      (instr_ready_in),
        .instr_read_value_in (instr_read_value_in),
        .pc_out              (pc_out),
        .instr_out           (instr_out)
    );

    assign instr_read_value_in = {16'hC0DE, instr_address_out[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reset, then release; returns in FETCH with pc = 0x100.
    task automatic start();
        reset = 1'b1;
        stall_in = 1'b0; flush_in = 1'b0; branch_taken_in = 1'b0;
        branch_pc_in = 32'h0; instr_ready_in = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall_in = 1'b0; flush_in = 1'b0; branch_taken_in = 1'b0;
        branch_pc_in = 32'h0; instr_ready_in = 1'b1;
        cyc(); cyc();
        tests_run++; if (instr_read_out !== 1'b0) begin tests_failed++; $display("FAIL reset_read: got %b want 0", instr_read_out); end
        tests_run++; if (pc_out !== 32'h100) begin tests_failed++; $display("FAIL reset_pc_out: got %h want 00000100", pc_out); end
        tests_run++; if (instr_out !== NOP) begin tests_failed++; $display("FAIL reset_instr: got %h want %h", instr_out, NOP); end
        reset = 1'b0;
        #1;
        tests_run++; if (instr_read_out !== 1'b0) begin tests_failed++; $display("FAIL idle_read: got %b want 0", instr_read_out); end
        cyc();
        tests_run++; if (instr_read_out !== 1'b1) begin tests_failed++; $display("FAIL first_read: got %b want 1", instr_read_out); end
        tests_run++; if (instr_address_out !== 32'h100) begin tests_failed++; $display("FAIL first_addr: got %h want 00000100", instr_address_out); end
        tests_run++; if (instr_out !== NOP) begin tests_failed++; $display("FAIL first_instr: got %h want %h", instr_out, NOP); end
        $display("[TB] reset: done");
    endtask

    task automatic test_sequential();
        start();
        cyc();
        tests_run++; if (instr_address_out !== 32'h104) begin tests_failed++; $display("FAIL seq_addr1: got %h want 00000104", instr_address_out); end
        tests_run++; if (pc_out !== 32'h100) begin tests_failed++; $display("FAIL seq_pc1: got %h want 00000100", pc_out); end
        tests_run++; if (instr_out !== 32'hC0DE_0100) begin tests_failed++; $display("FAIL seq_instr1: got %h want c0de0100", instr_out); end
        cyc();
        tests_run++; if (instr_address_out !== 32'h108) begin tests_failed++; $display("FAIL seq_addr2: got %h want 00000108", instr_address_out); end
        tests_run++; if (pc_out !== 32'h104) begin tests_failed++; $display("FAIL seq_pc2: got %h want 00000104", pc_out); end
        tests_run++; if (instr_out !== 32'hC0DE_0104) begin tests_failed++; $display("FAIL seq_instr2: got %h want c0de0104", instr_out); end
        $display("[TB] sequential: done");
    endtask

    task automatic test_wait_states();
        start();
        cyc();
        instr_ready_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            tests_run++; if (instr_address_out !== 32'h104) begin tests_failed++; $display("FAIL wait_addr%0d: got %h want 00000104", i, instr_address_out); end
            tests_run++; if (instr_out !== NOP) begin tests_failed++; $display("FAIL wait_instr%0d: got %h want %h", i, instr_out, NOP); end
        end
        instr_ready_in = 1'b1;
        cyc();
        tests_run++; if (instr_out !== 32'hC0DE_0104) begin tests_failed++; $display("FAIL wait_deliver: got %h want c0de0104", instr_out); end
        tests_run++; if (pc_out !== 32'h104) begin tests_failed++; $display("FAIL wait_deliver_pc: got %h want 00000104", pc_out); end
        cyc();
        tests_run++; if (instr_out !== 32'hC0DE_0108) begin tests_failed++; $display("FAIL wait_once: got %h want c0de0108", instr_out); end
        $display("[TB] wait_states: done");
    endtask

    task automatic test_stall();
        logic exp_read;
        start();
        cyc(); cyc();
        stall_in = 1'b1;
`ifdef RV32_FETCH_BUFFER_EN
        exp_read = 1'b0;
`else
        exp_read = 1'b1;
`endif
        for (int i = 0; i < 3; i++) begin
            cyc();
            tests_run++; if (pc_out !== 32'h104) begin tests_failed++; $display("FAIL stall_pc%0d: got %h want 00000104", i, pc_out); end
            tests_run++; if (instr_out !== 32'hC0DE_0104) begin tests_failed++; $display("FAIL stall_instr%0d: got %h want c0de0104", i, instr_out); end
            tests_run++; if (instr_read_out !== exp_read) begin tests_failed++; $display("FAIL stall_read%0d: got %b want %b", i, instr_read_out, exp_read); end
        end
        stall_in = 1'b0;
        cyc();
        tests_run++; if (instr_out !== 32'hC0DE_0108) begin tests_failed++; $display("FAIL stall_release_instr: got %h want c0de0108", instr_out); end
        tests_run++; if (instr_address_out !== 32'h10C) begin tests_failed++; $display("FAIL stall_release_addr: got %h want 0000010c", instr_address_out); end
        $display("[TB] stall: done");
    endtask

    task automatic test_branch_discard();
        start();
        cyc(); cyc(); cyc();
        instr_ready_in = 1'b0; branch_taken_in = 1'b1; branch_pc_in = 32'h200;
        cyc();
        branch_taken_in = 1'b0;
        tests_run++; if (instr_address_out !== 32'h10C) begin tests_failed++; $display("FAIL disc_addr0: got %h want 0000010c", instr_address_out); end
        tests_run++; if (instr_read_out !== 1'b1) begin tests_failed++; $display("FAIL disc_read: got %b want 1", instr_read_out); end
        cyc();
        tests_run++; if (instr_address_out !== 32'h10C) begin tests_failed++; $display("FAIL disc_addr1: got %h want 0000010c", instr_address_out); end
        tests_run++; if (instr_out !== NOP) begin tests_failed++; $display("FAIL disc_instr1: got %h want %h", instr_out, NOP); end
        instr_ready_in = 1'b1;
        cyc();
        tests_run++; if (instr_address_out !== 32'h200) begin tests_failed++; $display("FAIL disc_target: got %h want 00000200", instr_address_out); end
        tests_run++; if (instr_out !== NOP) begin tests_failed++; $display("FAIL disc_dropped: got %h want %h", instr_out, NOP); end
        cyc();
        tests_run++; if (instr_out !== 32'hC0DE_0200) begin tests_failed++; $display("FAIL disc_next_instr: got %h want c0de0200", instr_out); end
        tests_run++; if (pc_out !== 32'h200) begin tests_failed++; $display("FAIL disc_next_pc: got %h want 00000200", pc_out); end
        $display("[TB] branch_discard: done");
    endtask

    task automatic test_branch_ready();
        start();
        cyc();
        branch_taken_in = 1'b1; branch_pc_in = 32'h203;
        cyc();
        branch_taken_in = 1'b0;
        tests_run++; if (instr_address_out !== 32'h200) begin tests_failed++; $display("FAIL br_addr: got %h want 00000200", instr_address_out); end
        tests_run++; if (instr_out !== NOP) begin tests_failed++; $display("FAIL br_bubble: got %h want %h", instr_out, NOP); end
        tests_run++; if (pc_out !== 32'h104) begin tests_failed++; $display("FAIL br_bubble_pc: got %h want 00000104", pc_out); end
        cyc();
        tests_run++; if (instr_out !== 32'hC0DE_0200) begin tests_failed++; $display("FAIL br_target_instr: got %h want c0de0200", instr_out); end
        $display("[TB] branch_ready: done");
    endtask

    task automatic test_wrap_flush();
        start();
        branch_taken_in = 1'b1; branch_pc_in = 32'hFFFF_FFFC;
        cyc();
        branch_taken_in = 1'b0;
        tests_run++; if (instr_address_out !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_addr0: got %h want fffffffc", instr_address_out); end
        cyc();
        tests_run++; if (instr_address_out !== 32'h0) begin tests_failed++; $display("FAIL wrap_addr1: got %h want 00000000", instr_address_out); end
        tests_run++; if (instr_out !== 32'hC0DE_FFFC) begin tests_failed++; $display("FAIL wrap_instr: got %h want c0defffc", instr_out); end
        flush_in = 1'b1;
        cyc();
        flush_in = 1'b0;
        tests_run++; if (instr_out !== NOP) begin tests_failed++; $display("FAIL flush_instr: got %h want %h", instr_out, NOP); end
        tests_run++; if (pc_out !== 32'h0) begin tests_failed++; $display("FAIL flush_pc: got %h want 00000000", pc_out); end
        tests_run++; if (instr_address_out !== 32'h4) begin tests_failed++; $display("FAIL flush_addr: got %h want 00000004", instr_address_out); end
        cyc();
        tests_run++; if (instr_out !== 32'hC0DE_0004) begin tests_failed++; $display("FAIL flush_after: got %h want c0de0004", instr_out); end
        $display("[TB] wrap_flush: done");
    endtask

    task automatic test_reset_mid_request();
        start();
        cyc();
        instr_ready_in = 1'b0;
        cyc();
        #2;
        reset = 1'b1;
        #1;
        tests_run++; if (instr_read_out !== 1'b0) begin tests_failed++; $display("FAIL async_read: got %b want 0", instr_read_out); end
        tests_run++; if (pc_out !== 32'h100) begin tests_failed++; $display("FAIL async_pc: got %h want 00000100", pc_out); end
        tests_run++; if (instr_address_out !== 32'h100) begin tests_failed++; $display("FAIL async_addr: got %h want 00000100", instr_address_out); end
        cyc();
        reset = 1'b0;
        $display("[TB] reset_mid_request: done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_stall();
        test_branch_discard();
        test_branch_ready();
        test_wrap_flush();
        test_reset_mid_request();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
